bram_fifo_ctrl: RTL

Synchronous FIFO controller sitting directly upstream of the simple dual-port block RAM: turns a valid/ready write stream into RAM write strobes and RAM reads back into a valid/ready output stream. Owns the read/write pointers, occupancy and a two-entry output buffer that hides the RAM's one-cycle registered read latency, so `m_data` can stream at one word per cycle. The RAM array itself is instantiated beside this block, not inside it.

---
 rtl/bram_fifo_pkg.sv | 27 ++
 rtl/bram_fifo_obuf.sv | 85 ++++++++
 rtl/bram_fifo_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/bram_fifo_pkg.sv
// bram_fifo_pkg
//   Shared types and helpers for the bram_fifo_ctrl slice.
//   obuf_state_t : output-buffer fill state; the encoding equals the
//                  number of words held (0, 1, 2).
//   ptr_diff     : modular difference of two pointers of a given width.
package bram_fifo_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } obuf_state_t;

   localparam int unsigned PTR_FN_W = 32;

   // (a - b) modulo 2^w, for pointers carried in the low w bits.
   function automatic logic [PTR_FN_W-1:0] ptr_diff(
      input logic [PTR_FN_W-1:0] a,
      input logic [PTR_FN_W-1:0] b,
      input int unsigned         w
   );
      logic [PTR_FN_W-1:0] mask;
      mask = (PTR_FN_W'(1) << w) - PTR_FN_W'(1);
      return (a - b) & mask;
   endfunction

endpackage

// File: rtl/bram_fifo_obuf.sv
// bram_fifo_obuf
//   Two-entry output buffer in front of the FIFO output stream. Absorbs the
//   one-cycle registered read latency of the RAM so that the head word can
//   be consumed every cycle.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   push_i       a RAM read word arrives this cycle (write to tail)
//   push_data_i  the arriving word
//   pop_i        head word is consumed this cycle
//   m_data_o     head word
//   m_valid_o    head word is valid (state not EMPTY)
//   occ_o        words held: 0, 1 or 2
module bram_fifo_obuf
   import bram_fifo_pkg::*;
#(
   parameter int unsigned WIDTH = 72
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] m_data_o,
   output logic             m_valid_o,
   output logic [1:0]       occ_o
);

   obuf_state_t      state_q, state_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (state_q)
         EMPTY: begin
            if (push_i) begin
               head_d  = push_data_i;
               state_d = ONE;
            end
         end
         ONE: begin
            if (push_i && pop_i) begin
               head_d = push_data_i;
            end else if (push_i) begin
               tail_d  = push_data_i;
               state_d = TWO;
            end else if (pop_i) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            // A push while TWO is only possible together with a pop; the
            // read scheduler upstream never lets a third word arrive.
            if (pop_i) begin
               head_d = tail_q;
               if (push_i) begin
                  tail_d = push_data_i;
               end else begin
                  state_d = ONE;
               end
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   assign m_data_o  = head_q;
   assign m_valid_o = (state_q != EMPTY);
   assign occ_o     = 2'(state_q);

endmodule

// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl
//   Synchronous FIFO controller for an external simple dual-port block RAM
//   with a registered (one-cycle) read. Owns read/write pointers, occupancy
//   and a two-entry output buffer (bram_fifo_obuf).
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   s_data/s_valid/s_ready           write stream
//   m_data/m_valid/m_ready           read stream (buffer head)
//   ram_wdata/ram_waddr/ram_wen      RAM write port
//   ram_raddr/ram_ren/ram_rdata      RAM read port (rdata valid cycle after ren)
//   count                            words held: RAM + in-flight + buffer
// Optional feature, macro BRAM_FIFO_CTRL_ALMOST_EN:
//   adds registered almost_full (count >= DEPTH+2-AF_MARGIN) and
//   almost_empty (count <= 1).
module bram_fifo_ctrl
   import bram_fifo_pkg::*;
#(
   parameter int unsigned WIDTH     = 72,
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned AF_MARGIN = 4,
   localparam int unsigned AW       = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] ram_wdata,
   output logic [AW-1:0]    ram_waddr,
   output logic             ram_wen,
   output logic [AW-1:0]    ram_raddr,
   output logic             ram_ren,
   input  logic [WIDTH-1:0] ram_rdata,
   output logic [AW:0]      count
`ifdef BRAM_FIFO_CTRL_ALMOST_EN
   ,
   output logic             almost_full,
   output logic             almost_empty
`endif
);

   localparam int unsigned   PW       = AW + 1;
   localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

   if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || AF_MARGIN > DEPTH + 2) begin : g_param_check
      $error("bram_fifo_ctrl: DEPTH must be a power of two >= 4, AF_MARGIN <= DEPTH+2");
   end

   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [PW-1:0] mem_cnt;
   logic [PW-1:0] count_q, count_d;
   logic          inflight_q, inflight_d;
   logic [1:0]    occ;
   logic [2:0]    load;
   logic          pop;
   logic          wen;
   logic          ren;

   assign mem_cnt = PW'(ptr_diff(32'(wptr_q), 32'(rptr_q), PW));
   assign pop     = m_valid && m_ready;

   // The word leaving the buffer this cycle frees its slot in time for a
   // read issued now, which keeps a continuous stream bubble-free while
   // never letting buffer + in-flight exceed two words.
   assign load = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};

   always_comb begin
      wen        = s_valid && s_ready;
      ren        = !rst && (mem_cnt != '0) && (load < 3'd2);
      wptr_d     = wptr_q + PW'(wen);
      rptr_d     = rptr_q + PW'(ren);
      inflight_d = ren;
      count_d    = mem_cnt + PW'(inflight_q) + PW'(occ);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         inflight_q <= 1'b0;
         count_q    <= '0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
      end
   end

   bram_fifo_obuf #(
      .WIDTH (WIDTH)
   ) u_obuf (
      .clk         (clk),
      .rst         (rst),
      .push_i      (inflight_q),
      .push_data_i (ram_rdata),
      .pop_i       (pop),
      .m_data_o    (m_data),
      .m_valid_o   (m_valid),
      .occ_o       (occ)
   );

   assign s_ready   = !rst && (mem_cnt != FULL_CNT);
   assign ram_wen   = wen;
   assign ram_waddr = wptr_q[AW-1:0];
   assign ram_wdata = s_data;
   assign ram_ren   = ren;
   assign ram_raddr = rptr_q[AW-1:0];
   assign count     = count_q;

`ifdef BRAM_FIFO_CTRL_ALMOST_EN
   localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH + 2 - AF_MARGIN);

   logic af_q;
   logic ae_q;

   // Thresholds are taken on count_d so the flags move together with count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         af_q <= 1'b0;
         ae_q <= 1'b1;
      end else begin
         af_q <= (count_d >= AF_LEVEL);
         ae_q <= (count_d <= PW'(1));
      end
   end

   assign almost_full  = af_q;
   assign almost_empty = ae_q;
`endif

endmodule
